// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 single-bit mux.
// Owns the one-hot grant and 2-bit select, limits each tenure to MAX_HOLD
// cycles and optionally inserts one dead cycle between owners.
module mux41_rr_arbiter #(
  parameter int unsigned MAX_HOLD   = 4,  // 1..16
  parameter int unsigned TURNAROUND = 1   // 1 = dead cycle between owners
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] c,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       z
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] last_q,  last_d;
  logic [3:0] hold_q,  hold_d;

  logic [2:0] win_last;  // {found, index} scanning after last_q
  logic [2:0] win_sel;   // {found, index} scanning after the releasing owner
  logic       release_now;

  // Scan last+1 .. last+4 (mod 4); first active request wins, so the
  // previous owner is checked last and only re-wins when nobody else asks.
  function automatic logic [2:0] arbitrate(input logic [3:0] r,
                                           input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // State and datapath registers; asynchronous reset restores priority to requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: arbitration, hold counting and tenure release.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    last_d      = last_q;
    hold_d      = hold_q;
    win_last    = arbitrate(req, last_q);
    win_sel     = arbitrate(req, sel_q);
    release_now = !req[sel_q] || (hold_q == HOLD_LAST);

    unique case (state_q)
      IDLE, TURN: begin
        // TURN arbitrates with last_q already updated at the release edge.
        if (win_last[2]) begin
          grant_d = 4'b0001 << win_last[1:0];
          sel_d   = win_last[1:0];
          hold_d  = '0;
          state_d = GRANT;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_d = sel_q;
          hold_d = '0;
          if (TURNAROUND != 0) begin
            grant_d = '0;
            state_d = TURN;
          end else if (win_sel[2]) begin
            // Back-to-back handover: arbitrate as if last had already moved to sel.
            grant_d = 4'b0001 << win_sel[1:0];
            sel_d   = win_sel[1:0];
            state_d = GRANT;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registered grant/select; z is gated off when idle.
  always_comb begin
    grant = grant_q;
    sel   = sel_q;
    busy  = |grant_q;
    z     = (|grant_q) & c[sel_q];
  end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 single-bit mux. Four requesters compete for the mux path.
- The block owns the 2-bit select and one-hot grant, bounds each tenure with a hold counter, and can insert an optional dead cycle between owners.
- The muxed bit z is produced internally from the registered select.
- Sits between the requester logic and the downstream single-bit consumer.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one owner may hold the grant (legal range 1..16).
TURNAROUND, 1, 1 = one dead cycle (no grant) between owners; 0 = back-to-back handover.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
req  input  4  per-requester request; req[i] high = requester i wants the path.
c  input  4  data bits; c[i] belongs to requester i.
grant  output  4  one-hot current owner; 0000 when nobody owns the path.
sel  output  2  binary index of the current or most recent owner; drives the mux select.
busy  output  1  high while any grant is active (= |grant).
z  output  1  c[sel] when busy, else 0 (combinational from registered sel/busy).

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values, applied immediately on rst assertion regardless of clk:
  - state=IDLE, grant=0000, sel=00, busy=0, z=0
  - hold_cnt=0
  - last pointer=3, so requester 0 has the highest priority first.
- Arbitration function: scan indices last+1, last+2, last+3, last+4 (mod 4). The first i with req[i]=1 wins. The previous owner is therefore lowest priority.
- States:
  - IDLE:
    - If req==0000: stay, outputs idle.
    - Else: at this edge grant<=onehot(win), sel<=win, busy<=1, hold_cnt<=0; go to GRANT.
    - Latency: req high before edge k gives grant visible after edge k (1 cycle).
  - GRANT:
    - Each edge: hold_cnt<=hold_cnt+1, saturating at MAX_HOLD-1.
    - Release condition: req[sel]==0 OR hold_cnt==MAX_HOLD-1 (the grant has been visible MAX_HOLD cycles).
    - On release: last<=sel.
    - TURNAROUND=1: grant<=0000, busy<=0; go to TURN.
    - TURNAROUND=0: if any req is eligible, grant the arbitration winner at this same edge (hold_cnt<=0, stay in GRANT); otherwise grant<=0000, busy<=0, go to IDLE.
    - Eligibility: the releasing owner is eligible only if its req is still high (hold expiry). It can re-win only when no other requester is active.
  - TURN (exactly one cycle, grant=0000):
    - At its end edge, arbitrate using the updated last. A winner goes to GRANT; req==0000 goes to IDLE.
- sel keeps the last owner index while idle; z is forced to 0 whenever busy=0.
- req changes by non-owners during a tenure have no effect on the current grant.
- Simultaneous release and new requests: new requests are sampled at the release edge (TURNAROUND=0) or the TURN end edge (TURNAROUND=1).
- MAX_HOLD=1: every tenure lasts exactly one cycle.
- rst mid-tenure: all outputs clear asynchronously, last returns to 3, any partial hold count is discarded.
- Invariants (assert in bench):
  - grant is one-hot or zero.
  - busy == |grant.
  - When busy, grant == onehot(sel).
  - No grant is visible for more than MAX_HOLD consecutive cycles.

Test Plan:
1. Reset: rst=1, req=0000, c=1111 -> grant=0000, sel=00, busy=0, z=0. Assert rst between clock edges -> outputs clear before the next edge.
2. Single requester, hold expiry: req=0001 held 12 cycles, c=0001, MAX_HOLD=4, TURNAROUND=1 -> grant=0001 for 4 cycles (z=1), 1 cycle 0000, 0001 for 4, 0000, and so on.
3. Full contention: req=1111 constant -> grant order 0001, 0010, 0100, 1000, 0001, each 4 cycles with a 1-cycle gap. sel tracks 0,1,2,3,0.
4. Early release: req=0110 from reset release -> grant=0010 first. Drop req[1] after its 2nd grant cycle -> grant=0000 for 1 cycle, then 0100 for 4 cycles.
5. TURNAROUND=0 instance, req=0101 -> 0001 for 4 cycles, then immediately 0100 for 4 cycles, then 0001, with busy never low.
6. Mid-tenure reset: while grant=0100, pulse rst -> grant=0000 immediately. Then apply req=1001 -> grant=0001 first (last=3 after reset).
